// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and timer width helper.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  // Timer must hold the larger of the two reload values (HOLD-1 / GAP-1) with headroom.
  function automatic int calc_cnt_w(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Up/down saturating event counter with a sticky overflow flag for dropped increments.
module sat_counter #(
  parameter int MAX = 3,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr_ovf,
  output logic [W-1:0] count,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic drop;

  // An increment with no matching decrement while full is lost.
  assign drop = inc && !dec && (count == MAX_V);

  // Count update; a simultaneous inc and dec cancel out and leave the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != MAX_V) count <= count + 1'b1;
    end else if (dec && !inc) begin
      if (count != '0) count <= count - 1'b1;
    end
  end

  // Sticky overflow; a new drop beats a clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into fixed-width high levels with a guaranteed low gap.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | output low, nothing pending
//   HOLD    | output high, timer counts down the hold width
//   GAP     | output low, timer counts down the minimum gap; then next
//           | queued strobe (or a strobe on the final edge) starts HOLD
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PEND    = 3,
  parameter int RETRIGGER   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pulse_i,
  input  logic                          clr_ovf_i,
  output logic                          s_o,
  output logic                          busy_o,
  output logic [$clog2(MAX_PEND+1)-1:0] pending_o,
  output logic                          overflow_o
);

  localparam int CW = calc_cnt_w(HOLD_CYCLES, GAP_CYCLES);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          enq, deq;

  // State, timer and registered outputs; s_o/busy_o are decoded from the next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      s_o    <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      s_o    <= (state_nxt == ST_HOLD);
      busy_o <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state, timer reloads and queue push/pop requests.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    enq       = 1'b0;
    deq       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pulse_i) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if ((RETRIGGER != 0) && pulse_i) begin
          cnt_nxt = HOLD_LOAD;
        end else begin
          enq = pulse_i;
          if (cnt == '0) begin
            state_nxt = ST_GAP;
            cnt_nxt   = GAP_LOAD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          if (pending_o != '0) begin
            // Pop one queued strobe; a strobe on this same edge takes its slot.
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LOAD;
            deq       = 1'b1;
            enq       = pulse_i;
          end else if (pulse_i) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = HOLD_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
          enq     = pulse_i;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  sat_counter #(
    .MAX (MAX_PEND),
    .W   (PW)
  ) u_pend (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (enq),
    .dec     (deq),
    .clr_ovf (clr_ovf_i),
    .count   (pending_o),
    .ovf     (overflow_o)
  );

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: one queuing instance and one retriggering instance.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse0, pulse1, clr_ovf;
  logic       s0, busy0, ovf0;
  logic       s1, busy1, ovf1;
  logic [1:0] pend0, pend1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HOLD_CYCLES (4), .GAP_CYCLES (2), .MAX_PEND (3), .RETRIGGER (0)
  ) dut0 (
    .clk (clk), .rst_n (rst_n), .pulse_i (pulse0), .clr_ovf_i (clr_ovf),
    .s_o (s0), .busy_o (busy0), .pending_o (pend0), .overflow_o (ovf0)
  );

  pulse_stretcher #(
    .HOLD_CYCLES (4), .GAP_CYCLES (2), .MAX_PEND (3), .RETRIGGER (1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n), .pulse_i (pulse1), .clr_ovf_i (clr_ovf),
    .s_o (s1), .busy_o (busy1), .pending_o (pend1), .overflow_o (ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives pv[i] before edge i and checks outputs just after edge i against the masks.
  // Pending is checked bitwise: p1v holds bit 1, p0v holds bit 0 of the expected count.
  task automatic run(input int which, input int n, input logic [31:0] pv,
                     input logic [31:0] sv, input logic [31:0] bv,
                     input logic [31:0] p1v, input logic [31:0] p0v,
                     input logic [31:0] ov, input string tag);
    for (int i = 0; i < n; i++) begin
      if (which == 0) pulse0 = pv[i];
      else            pulse1 = pv[i];
      @(posedge clk);
      #1;
      if (which == 0) begin
        chk($sformatf("%s_s[%0d]", tag, i),    {31'b0, s0},    {31'b0, sv[i]});
        chk($sformatf("%s_busy[%0d]", tag, i), {31'b0, busy0}, {31'b0, bv[i]});
        chk($sformatf("%s_pend[%0d]", tag, i), {30'b0, pend0}, {30'b0, p1v[i], p0v[i]});
        chk($sformatf("%s_ovf[%0d]", tag, i),  {31'b0, ovf0},  {31'b0, ov[i]});
      end else begin
        chk($sformatf("%s_s[%0d]", tag, i),    {31'b0, s1},    {31'b0, sv[i]});
        chk($sformatf("%s_busy[%0d]", tag, i), {31'b0, busy1}, {31'b0, bv[i]});
        chk($sformatf("%s_pend[%0d]", tag, i), {30'b0, pend1}, {30'b0, p1v[i], p0v[i]});
        chk($sformatf("%s_ovf[%0d]", tag, i),  {31'b0, ovf1},  {31'b0, ov[i]});
      end
    end
    pulse0 = 1'b0;
    pulse1 = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    pulse0  = 1'b0;
    pulse1  = 1'b0;
    clr_ovf = 1'b0;

    // Reset held with strobes toggling: everything stays quiet.
    for (int i = 0; i < 6; i++) begin
      pulse0 = i[0];
      pulse1 = ~i[0];
      @(posedge clk);
      #1;
      chk("rst_s0",    {31'b0, s0},    32'd0);
      chk("rst_busy0", {31'b0, busy0}, 32'd0);
      chk("rst_pend0", {30'b0, pend0}, 32'd0);
      chk("rst_ovf0",  {31'b0, ovf0},  32'd0);
      chk("rst_s1",    {31'b0, s1},    32'd0);
      chk("rst_busy1", {31'b0, busy1}, 32'd0);
    end
    pulse0 = 1'b0;
    pulse1 = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single strobe: high edges 0-3, busy 0-5.
    run(0, 8, 32'h1, 32'h0000_000F, 32'h0000_003F, 32'h0, 32'h0, 32'h0, "single");

    // Three back-to-back strobes: blinks at 0, 6, 12; pending 2 -> 1 -> 0.
    run(0, 20, 32'h7, 32'h0000_F3CF, 32'h0003_FFFF, 32'h0000_003C, 32'h0000_0FC2,
        32'h0, "triple");

    // Five strobes: saturate at 3, fifth dropped, four blinks, overflow sticks.
    run(0, 32, 32'h1F, 32'h003C_F3CF, 32'h00FF_FFFF, 32'h0000_0FFC, 32'h0003_F03A,
        32'hFFFF_FFF0, "sat");

    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    chk("clr_ovf", {31'b0, ovf0}, 32'd0);
    chk("clr_pend", {30'b0, pend0}, 32'd0);

    // Retrigger instance: strobes at 0 and 2 give one continuous blink 0-5.
    run(1, 12, 32'h5, 32'h0000_003F, 32'h0000_00FF, 32'h0, 32'h0, 32'h0, "retrig");

    // Async reset in HOLD with two strobes queued.
    run(0, 4, 32'h7, 32'h0000_000F, 32'h0000_000F, 32'h0000_000C, 32'h0000_0002,
        32'h0, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s",    {31'b0, s0},    32'd0);
    chk("arst_busy", {31'b0, busy0}, 32'd0);
    chk("arst_pend", {30'b0, pend0}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(0, 8, 32'h1, 32'h0000_000F, 32'h0000_003F, 32'h0, 32'h0, 32'h0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
